// File: rtl/fab_test_pkg.sv
// Shared definitions for the fabric bring-up test core.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package fab_test_pkg;

    // Operating modes, encoded exactly as driven on the mode pins.
    typedef enum logic [1:0] {
        MODE_ADD  = 2'd0,
        MODE_ACC  = 2'd1,
        MODE_CNT  = 2'd2,
        MODE_LFSR = 2'd3
    } mode_e;

    // Control FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // Galois feedback mask giving a maximal-length sequence at 8 bits.
    localparam logic [7:0] DEFAULT_LFSR_TAPS = 8'hB8;

    // Widest result the LFSR helper supports.
    localparam int LFSR_MAX_W = 64;

    // One Galois LFSR step: shift right, fold the taps in when the bit
    // shifted out is set. Callers zero-extend narrower values; the zero
    // upper bits stay zero because the taps are zero-extended too.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] value,
        input logic [LFSR_MAX_W-1:0] taps
    );
        lfsr_next = (value >> 1) ^ (value[0] ? taps : '0);
    endfunction

endpackage

// File: rtl/fab_test_core.sv
// Multi-mode fabric test core: ADD / ACC / CNT / LFSR on registered pin copies.
// Latency: pins sampled at edge n, result visible after edge n+1; mode change costs one LOAD cycle.
// Backpressure: none; en_q=0 in RUN simply holds dst and carry.
//
// Ports:
//   clk      fabric clock, rising edge
//   rst      synchronous active-high reset
//   a        operand A / load value / LFSR seed
//   b        operand B / counter step
//   mode     0=ADD 1=ACC 2=CNT 3=LFSR
//   en       advance enable
//   dst      registered result
//   carry    carry/flag of the last update
//   mode_ack one-cycle pulse while the core sits in LOAD
module fab_test_core
    import fab_test_pkg::*;
#(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   LFSR_TAPS = WIDTH'(DEFAULT_LFSR_TAPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    input  logic             en,
    output logic [WIDTH-1:0] dst,
    output logic             carry,
    output logic             mode_ack
);

    // ------------------------------------------------------------------
    // Pin register stage: everything downstream uses only these copies,
    // so there is never a combinational path from pins to outputs.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    mode_e            mode_q;
    logic             en_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= MODE_ADD;
            en_q   <= 1'b0;
        end else begin
            a_q    <= a;
            b_q    <= b;
            mode_q <= mode_e'(mode);
            en_q   <= en;
        end
    end

    // ------------------------------------------------------------------
    // Core state
    // ------------------------------------------------------------------
    state_e           state_q,    state_d;
    mode_e            cur_mode_q, cur_mode_d;
    logic [WIDTH-1:0] dst_q,      dst_d;
    logic             carry_q,    carry_d;
    logic             ack_q,      ack_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cur_mode_q <= MODE_ADD;
            dst_q      <= '0;
            carry_q    <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_mode_q <= cur_mode_d;
            dst_q      <= dst_d;
            carry_q    <= carry_d;
            ack_q      <= ack_d;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: one update in the active mode, and the value dst takes
    // when (re)entering LOAD in the newly selected mode.
    // ------------------------------------------------------------------
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] upd_dst;
    logic             upd_carry;
    logic [WIDTH-1:0] load_dst;

    always_comb begin
        sum       = '0;
        upd_dst   = dst_q;
        upd_carry = 1'b0;
        unique case (cur_mode_q)
            MODE_ADD: begin
                sum       = {1'b0, a_q} + {1'b0, b_q};
                upd_dst   = sum[WIDTH-1:0];
                upd_carry = sum[WIDTH];
            end
            MODE_ACC: begin
                sum       = {1'b0, dst_q} + {1'b0, a_q};
                upd_dst   = sum[WIDTH-1:0];
                upd_carry = sum[WIDTH];
            end
            MODE_CNT: begin
                // A zero step naturally holds the count with no carry.
                sum       = {1'b0, dst_q} + {1'b0, b_q};
                upd_dst   = sum[WIDTH-1:0];
                upd_carry = sum[WIDTH];
            end
            MODE_LFSR: begin
                upd_dst   = WIDTH'(lfsr_next(LFSR_MAX_W'(dst_q), LFSR_MAX_W'(LFSR_TAPS)));
                upd_carry = dst_q[0];
            end
            default: begin
                upd_dst   = dst_q;
                upd_carry = 1'b0;
            end
        endcase
    end

    always_comb begin
        load_dst = dst_q;
        unique case (mode_q)
            MODE_ADD:  load_dst = dst_q;
            MODE_ACC:  load_dst = '0;
            MODE_CNT:  load_dst = a_q;
            // An all-zero seed would lock the LFSR; substitute 1.
            MODE_LFSR: load_dst = (a_q == '0) ? WIDTH'(1) : a_q;
            default:   load_dst = dst_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM. The LOAD actions are applied on the edge that enters
    // LOAD, so dst already shows the initial value while mode_ack is
    // high; the edge leaving LOAD performs the first update.
    // ------------------------------------------------------------------
    logic do_load;
    logic do_upd;

    always_comb begin
        state_d    = state_q;
        cur_mode_d = cur_mode_q;
        dst_d      = dst_q;
        carry_d    = carry_q;
        ack_d      = 1'b0;
        do_load    = 1'b0;
        do_upd     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                do_load = en_q;
            end
            ST_LOAD: begin
                state_d = ST_RUN;
                do_upd  = en_q;
            end
            ST_RUN: begin
                // A mode change wins over the update on the same edge.
                if (mode_q != cur_mode_q) begin
                    do_load = 1'b1;
                end else begin
                    do_upd = en_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_load) begin
            state_d    = ST_LOAD;
            cur_mode_d = mode_q;
            dst_d      = load_dst;
            carry_d    = 1'b0;
            ack_d      = 1'b1;
        end else if (do_upd) begin
            dst_d   = upd_dst;
            carry_d = upd_carry;
        end
    end

    assign dst      = dst_q;
    assign carry    = carry_q;
    assign mode_ack = ack_q;

endmodule

// File: doc/fab_test_core.md
# fab_test_core

Parametrised multi-mode test core for bring-up of generated fabrics. It sits between the input and output IO buffer cells of the fabric test wrapper. It takes two WIDTH-bit operand buses and a mode select from pins, and drives a registered WIDTH-bit result plus a carry flag. Four modes (add, accumulate, step-counter, LFSR) exercise LUT, carry-chain and register resources with deterministic, self-checkable sequences.

## Interface
Parameters:
- WIDTH, 8: operand/result width, ≥ 2.
- LFSR_TAPS, 8'hB8: Galois feedback mask, WIDTH bits; default is maximal-length for WIDTH=8.

Ports:
- clk  in  1  fabric global clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- a  in  WIDTH  operand A / load value / LFSR seed.
- b  in  WIDTH  operand B / counter step.
- mode  in  2  0=ADD, 1=ACC, 2=CNT, 3=LFSR.
- en  in  1  advance enable.
- dst  out  WIDTH  result register.
- carry  out  1  carry/flag of the last update.
- mode_ack  out  1  one-cycle pulse in the LOAD cycle.

## Operation
- Input stage: a, b, mode and en are registered every cycle into a_q, b_q, mode_q and en_q. All logic uses the registered copies only.
- FSM states are IDLE, LOAD and RUN. Active mode register cur_mode.
  - IDLE → LOAD when en_q=1; otherwise stay in IDLE.
  - LOAD: cur_mode ← mode_q, mode_ack=1, dst initialised per mode:
    - ADD: dst held.
    - ACC: dst ← 0.
    - CNT: dst ← a_q.
    - LFSR: dst ← a_q, or 1 if a_q==0 (lock-up avoidance).
    - carry ← 0 in all modes. Always → RUN.
  - RUN: if mode_q≠cur_mode → LOAD (takes priority over the update). Else if en_q=1, update; if en_q=0, hold dst and carry.
- Updates (modulo 2^WIDTH, carry = bit WIDTH of the (WIDTH+1)-bit sum; carry is not sticky):
  - ADD: {carry,dst} ← a_q + b_q.
  - ACC: {carry,dst} ← dst + a_q.
  - CNT: {carry,dst} ← dst + b_q. b_q=0 holds the value with carry=0.
  - LFSR: carry ← dst[0]; dst ← (dst >> 1) ^ (dst[0] ? LFSR_TAPS : 0).
- Reset: rst=1 at any edge, including mid-RUN or mid-LOAD, forces the following state. Pin-register contents are don't-care.
  - State: IDLE.
  - Outputs: dst=0, carry=0, mode_ack=0.
  - Registers: cur_mode=ADD, en_q=0, mode_q=0.

## Timing
- Pin-to-dst latency in RUN (ADD): a/b stable before edge n → sampled at edge n → result visible after edge n+1.
- Start from IDLE: en=1 before edge 0 → LOAD after edge 1 → first update after edge 2.
- Mode change in RUN: new mode sampled at edge n → LOAD after edge n+1 (mode_ack high for exactly that cycle) → RUN after edge n+2.
- A mode toggled and restored within one cycle is absorbed if mode_q never differs from cur_mode at an edge.
- Outputs are directly registered, with no combinational pin-to-pin path.

## Structure
- Shared package fab_test_pkg holds:
  - mode encodings MODE_ADD/ACC/CNT/LFSR;
  - state enum ST_IDLE/ST_LOAD/ST_RUN;
  - default LFSR tap constant;
  - pure function lfsr_next(value, taps).
- Single flat module; no sub-module is warranted. The input register stage stays inline.
- Expected size 150–250 lines.

## Test plan
All at WIDTH=8.
1. Reset: hold rst=1 for 2 cycles with random pins → dst=8'h00, carry=0, mode_ack=0; with en=0 the core stays in IDLE (dst unchanged for 10 cycles).
2. ADD: mode=0, en=1, a=8'hF0, b=8'h20 → after LOAD, dst=8'h10, carry=1. Then a=8'h01, b=8'h02 → dst=8'h03, carry=0 two edges later.
3. ACC: mode=1, a=8'h40, en=1 → dst sequence 00 (LOAD), 40, 80, C0, 00 with carry=1 only on the 00 wrap. en=0 for 3 cycles → value and carry held.
4. CNT: mode=2, a=8'hFE, b=8'h01 → FE (LOAD), FF, 00 (carry=1), 01 (carry=0). Then b=8'h00 → dst held at the current value, carry=0.
5. LFSR: mode=3, a=8'h00 → seed 8'h01, next 8'hB8. dst returns to 8'h01 after exactly 255 updates and never reads 8'h00.
6. Mode change and mid-op reset: in RUN ACC, set mode=2, a=8'h33 → mode_ack is a single-cycle pulse, dst=8'h33, then counting resumes. Asserting rst for one cycle during RUN → dst=0 at the next edge, then IDLE → LOAD → RUN again once en=1.
